lorenz_sample_fifo: RTL

Decimating capture buffer between the fixed-point attractor integrator and the HPS-readable PIO ports. Takes the integrator's 27-bit signed X/Y/Z state on each step strobe and keeps one of every `decim+1` steps. Kept samples go into a small synchronous FIFO and are sign-extended to 32 bits. The HPS side drains them through a valid/ready handshake, so software sees every kept trajectory point exactly once, in order, with explicit loss accounting.

---
 rtl/lorenz_sample_fifo.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/lorenz_sample_fifo.sv
// Decimating capture FIFO for Lorenz integrator X/Y/Z state words.
// Ports:
//   clk, reset (sync, active-high)
//   in_valid, in_x/y/z : integrator step strobe and state
//   enable, decim      : capture enable, keep 1 of decim+1 steps
//   clear_ovf          : clears the sticky overflow flag
//   out_valid/ready    : FWFT consumer handshake
//   out_x/y/z          : sign-extended head entry
//   count, overflow    : occupancy and sticky loss flag
//   drop_count         : only with LORENZ_SAMPLE_FIFO_DROP_CNT_EN defined
module lorenz_sample_fifo #(
    parameter int DATA_W  = 27,
    parameter int OUT_W   = 32,
    parameter int DEPTH   = 16,
    parameter int DECIM_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_x,
    input  logic [DATA_W-1:0]        in_y,
    input  logic [DATA_W-1:0]        in_z,
    input  logic                     enable,
    input  logic [DECIM_W-1:0]       decim,
    input  logic                     clear_ovf,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OUT_W-1:0]         out_x,
    output logic [OUT_W-1:0]         out_y,
    output logic [OUT_W-1:0]         out_z,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
`ifdef LORENZ_SAMPLE_FIFO_DROP_CNT_EN
    ,
    output logic [15:0]              drop_count
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = 3 * DATA_W;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_EMPTY,
        S_PARTIAL,
        S_FULL
    } state_e;

    state_e state_q, state_d;

    logic [CW-1:0]      count_q, count_d;
    logic [AW-1:0]      rd_q, rd_d;
    logic [AW-1:0]      wr_q, wr_d;
    logic [DECIM_W-1:0] dcnt_q, dcnt_d;
    logic               ovf_q, ovf_d;
    logic               valid_q, valid_d;
    logic [OUT_W-1:0]   ox_q, ox_d;
    logic [OUT_W-1:0]   oy_q, oy_d;
    logic [OUT_W-1:0]   oz_q, oz_d;
    logic [EW-1:0]      mem_q [DEPTH];
    logic [EW-1:0]      in_w;
    logic [EW-1:0]      head_w;

    logic kept;
    logic pop;
    logic push;
    logic drop;

    assign in_w = {in_x, in_y, in_z};

    // Decimation: keep on dcnt==0, then reload from decim.
    always_comb begin
        kept   = 1'b0;
        dcnt_d = dcnt_q;
        if (!enable) begin
            dcnt_d = '0;
        end else if (in_valid) begin
            if (dcnt_q == '0) begin
                kept   = 1'b1;
                dcnt_d = decim;
            end else begin
                dcnt_d = dcnt_q - 1'b1;
            end
        end
    end

    // A full FIFO still accepts a push when the head leaves this cycle.
    assign pop  = valid_q && out_ready;
    assign push = kept && ((state_q != S_FULL) || pop);
    assign drop = kept && !push;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        if (push) begin
            wr_d = wr_q + 1'b1;
        end
        if (pop) begin
            rd_d = rd_q + 1'b1;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (count_d == '0) begin
            state_d = S_EMPTY;
        end else if (count_d == FULL_CNT) begin
            state_d = S_FULL;
        end else begin
            state_d = S_PARTIAL;
        end
        valid_d = (count_d != '0);
    end

    // Next head may be the word being written right now (bypass).
    always_comb begin
        if (push && (rd_d == wr_q)) begin
            head_w = in_w;
        end else begin
            head_w = mem_q[rd_d];
        end
        ox_d = ox_q;
        oy_d = oy_q;
        oz_d = oz_q;
        if (valid_d) begin
            ox_d = OUT_W'($signed(head_w[3*DATA_W-1:2*DATA_W]));
            oy_d = OUT_W'($signed(head_w[2*DATA_W-1:DATA_W]));
            oz_d = OUT_W'($signed(head_w[DATA_W-1:0]));
        end
    end

    // A fresh drop wins over a simultaneous clear.
    always_comb begin
        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (clear_ovf) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_EMPTY;
            count_q <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            dcnt_q  <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
            ox_q    <= '0;
            oy_q    <= '0;
            oz_q    <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            dcnt_q  <= dcnt_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
            ox_q    <= ox_d;
            oy_q    <= oy_d;
            oz_q    <= oz_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem_q[wr_q] <= in_w;
        end
    end

    assign out_valid = valid_q;
    assign out_x     = ox_q;
    assign out_y     = oy_q;
    assign out_z     = oz_q;
    assign count     = count_q;
    assign overflow  = ovf_q;

`ifdef LORENZ_SAMPLE_FIFO_DROP_CNT_EN
    logic [15:0] dc_q, dc_d;

    always_comb begin
        dc_d = dc_q;
        if (drop) begin
            if (clear_ovf) begin
                dc_d = 16'd1;
            end else if (dc_q != 16'hFFFF) begin
                dc_d = dc_q + 16'd1;
            end
        end else if (clear_ovf) begin
            dc_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dc_q <= '0;
        end else begin
            dc_q <= dc_d;
        end
    end

    assign drop_count = dc_q;
`endif

endmodule
